// File: rtl/spi_memory_slave_if.sv
// Signal bundle between the SPI mode-0 slave front end, its pin conditioners and the
// register memory it reads and writes.
interface spi_memory_slave_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  cs_cond;
  logic                  sclk_pos;
  logic                  sclk_neg;
  logic                  mosi_cond;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  miso_out;
  logic                  miso_oe;
  logic                  busy;

  modport slave (
    input  cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    output mem_addr, mem_wdata, mem_we, miso_out, miso_oe, busy
  );

  modport master (
    output cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, miso_out, miso_oe, busy
  );
endinterface

// File: rtl/spi_memory_slave.sv
// SPI mode-0 slave: decodes an address + R/W header, then writes one word to memory
// or reads one word and shifts it out on MISO.
module spi_memory_slave #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  spi_memory_slave_if.slave bus
);

  // Largest pre-shift history needed: the address bits, or all but the last data bit.
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HDR_LAST  = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    RD_WAIT,
    RD_LOAD,
    RD_SHIFT,
    WR_DATA,
    WR_COMMIT,
    DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [CNT_MAX-1:0]    shift_in;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  miso_oe;
  logic                  busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (state == IDLE) begin
        if (!bus.cs_cond) begin
          state   <= HEADER;
          bit_cnt <= '0;
          busy    <= 1'b1;
        end
      end else if (state == WR_COMMIT) begin
        // The strobe is issued even if CS rises now, so a completed write is never lost.
        mem_we <= 1'b1;
        state  <= DONE;
      end else if (bus.cs_cond) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          HEADER: begin
            if (bus.sclk_pos) begin
              shift_in <= {shift_in[CNT_MAX-2:0], bus.mosi_cond};
              if (bit_cnt == HDR_LAST) begin
                // NOTE: non-blocking updates mean shift_in here is still the pre-shift value,
                // so its low bits are exactly the address and mosi_cond is the R/W bit.
                mem_addr <= shift_in[ADDR_WIDTH-1:0];
                bit_cnt  <= '0;
                state    <= bus.mosi_cond ? RD_WAIT : WR_DATA;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
          end

          RD_WAIT: state <= RD_LOAD;

          RD_LOAD: begin
            shift_out <= bus.mem_rdata;
            miso_oe   <= 1'b1;
            state     <= RD_SHIFT;
          end

          RD_SHIFT: begin
            if (bus.sclk_pos) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                miso_oe <= 1'b0;
                state   <= DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end else if (bus.sclk_neg && bit_cnt != '0) begin
              // Zero count means this is the header's trailing falling edge: MSB must stay put.
              shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
            end
          end

          WR_DATA: begin
            if (bus.sclk_pos) begin
              shift_in <= {shift_in[CNT_MAX-2:0], bus.mosi_cond};
              if (bit_cnt == DATA_LAST) begin
                mem_wdata <= {shift_in[DATA_WIDTH-2:0], bus.mosi_cond};
                bit_cnt   <= '0;
                state     <= WR_COMMIT;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
          end

          DONE: miso_oe <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  assign bus.miso_out  = shift_out[DATA_WIDTH-1];
  assign bus.miso_oe   = miso_oe;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_memory_slave.sv
// Self-checking bench for spi_memory_slave: directed transactions followed by random
// reads/writes scored against a behavioural memory and MISO bit-order model.
module tb_spi_memory_slave;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  spi_memory_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_memory_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] tb_mem   [DEPTH];
  logic [DW-1:0] exp_mem  [DEPTH];
  logic [DW-1:0] last_wdata;
  logic          mem_init = 1'b1;

  // Memory behind the slave: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_mem[i];
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  int   we_count = 0;
  logic we_prev  = 1'b0;
  logic we_long  = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_we) we_count <= we_count + 1;
    if (bus.mem_we && we_prev) we_long <= 1'b1;
    we_prev <= bus.mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pos_pulse(input logic mosi, input logic with_neg);
    bus.mosi_cond = mosi;
    bus.sclk_pos  = 1'b1;
    bus.sclk_neg  = with_neg;
    tick();
    bus.sclk_pos  = 1'b0;
    bus.sclk_neg  = 1'b0;
  endtask

  task automatic neg_pulse();
    bus.sclk_neg = 1'b1;
    tick();
    bus.sclk_neg = 1'b0;
  endtask

  // One full SCLK period with 4-clk phases.
  task automatic send_bit(input logic b);
    pos_pulse(b, 1'b0);
    repeat (3) tick();
    neg_pulse();
    repeat (3) tick();
  endtask

  task automatic start_cs();
    bus.cs_cond = 1'b0;
    repeat (4) tick();
    check("cs_low_busy", bus.busy, 1'b1);
  endtask

  task automatic end_cs();
    bus.cs_cond = 1'b1;
    tick();
    check("cs_high_idle", bus.busy, 1'b0);
    check("cs_high_oe", bus.miso_oe, 1'b0);
    repeat (3) tick();
  endtask

  task automatic send_addr(input logic [AW-1:0] addr);
    for (int i = AW - 1; i >= 0; i--) send_bit(addr[i]);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int we0;
    start_cs();
    send_addr(addr);
    send_bit(1'b0);
    for (int i = DW - 1; i > 0; i--) send_bit(data[i]);
    we0 = we_count;
    pos_pulse(data[0], 1'b0);
    check("wr_we_lat1", bus.mem_we, 1'b0);
    tick();
    check("wr_we", bus.mem_we, 1'b1);
    check("wr_addr", bus.mem_addr, addr);
    check("wr_wdata", bus.mem_wdata, data);
    tick();
    check("wr_we_off", bus.mem_we, 1'b0);
    check("wr_we_count", we_count, we0 + 1);
    check("wr_done_busy", bus.busy, 1'b1);
    exp_mem[addr] = data;
    last_wdata    = data;
    repeat (2) tick();
    neg_pulse();
    repeat (3) tick();
  endtask

  task automatic do_write_abort(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input int nbits);
    int we0;
    we0 = we_count;
    start_cs();
    send_addr(addr);
    send_bit(1'b0);
    for (int i = DW - 1; i > DW - 1 - nbits; i--) send_bit(data[i]);
    check("abort_busy_before", bus.busy, 1'b1);
    bus.cs_cond = 1'b1;
    tick();
    check("abort_idle", bus.busy, 1'b0);
    check("abort_oe", bus.miso_oe, 1'b0);
    check("abort_wdata_hold", bus.mem_wdata, last_wdata);
    repeat (3) tick();
    check("abort_no_we", we_count, we0);
  endtask

  // coin_idx selects which data bit's rising edge carries a coincident falling pulse (>=DW: none).
  task automatic do_read(input logic [AW-1:0] addr, input int coin_idx);
    logic [DW-1:0] word;
    int            shifts;
    int            we0;
    logic          co;
    word   = exp_mem[addr];
    shifts = 0;
    we0    = we_count;
    start_cs();
    send_addr(addr);
    pos_pulse(1'b1, 1'b0);
    check("rd_oe_lat1", bus.miso_oe, 1'b0);
    check("rd_addr", bus.mem_addr, addr);
    tick();
    check("rd_oe_lat2", bus.miso_oe, 1'b0);
    tick();
    check("rd_oe_lat3", bus.miso_oe, 1'b1);
    check("rd_msb_lat3", bus.miso_out, word[DW-1]);
    tick();
    neg_pulse();
    repeat (3) tick();
    for (int k = 0; k < DW; k++) begin
      check("rd_oe", bus.miso_oe, 1'b1);
      check("rd_bit", bus.miso_out, word[DW-1-shifts]);
      co = (k == coin_idx);
      pos_pulse(1'($urandom), co);
      if (k < DW - 1) begin
        repeat (3) tick();
        if (co) begin
          tick();
        end else begin
          neg_pulse();
          shifts++;
        end
        repeat (3) tick();
      end
    end
    check("rd_done_oe", bus.miso_oe, 1'b0);
    check("rd_done_busy", bus.busy, 1'b1);
    repeat (3) tick();
    neg_pulse();
    repeat (3) tick();
    check("rd_no_we", we_count, we0);
  endtask

  initial begin
    int we0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    bus.cs_cond   = 1'b1;
    bus.sclk_pos  = 1'b0;
    bus.sclk_neg  = 1'b0;
    bus.mosi_cond = 1'b0;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
    init_mem[7'h15] = 8'hA5;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_mem[i];
    last_wdata = '0;

    repeat (2) tick();
    mem_init = 1'b0;
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_miso", bus.miso_out, 0);
    check("rst_oe", bus.miso_oe, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);

    // Write, then stray SCLK activity while parked in DONE.
    do_write(7'h2A, 8'hC3);
    we0 = we_count;
    for (int i = 0; i < 3; i++) begin
      pos_pulse(1'b1, 1'b0);
      repeat (3) tick();
    end
    check("done_busy", bus.busy, 1'b1);
    check("done_no_we", we_count, we0);
    check("done_wdata", bus.mem_wdata, 8'hC3);
    check("done_oe", bus.miso_oe, 1'b0);
    end_cs();

    // Reset held for two cycles in the middle of a header.
    start_cs();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    repeat (2) tick();
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_wdata", bus.mem_wdata, 0);
    check("mid_rst_we", bus.mem_we, 0);
    check("mid_rst_miso", bus.miso_out, 0);
    check("mid_rst_oe", bus.miso_oe, 0);
    check("mid_rst_busy", bus.busy, 0);
    reset       = 1'b0;
    bus.cs_cond = 1'b1;
    last_wdata  = '0;
    tick();
    check("post_rst_idle", bus.busy, 0);
    repeat (3) tick();

    do_write(7'h10, 8'h5A);
    end_cs();
    do_write_abort(7'h33, 8'hFF, 5);

    do_read(7'h15, DW);
    end_cs();

    // Back-to-back write then read of the same location, coincident pulse on bit 3.
    do_write(7'h7F, 8'h01);
    end_cs();
    do_read(7'h7F, 3);
    end_cs();

    for (int t = 0; t < 24; t++) begin
      ra = AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_read(ra, int'($urandom_range(0, 2 * DW)));
        end_cs();
      end else begin
        rd = DW'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          do_write_abort(ra, rd, int'($urandom_range(1, DW - 1)));
        end else begin
          do_write(ra, rd);
          end_cs();
        end
      end
    end

    check("we_never_long", we_long, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
